ddfs_frequency_readback: RTL and testbench

//  Inverse of the keypad frequency converter: takes the tuning word fw, the decade-divider

---
 rtl/ddfs_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 79 +++++++
 rtl/ddfs_frequency_readback.sv | 175 +++++++++++++++++
 tb/tb_ddfs_frequency_readback.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// ddfs_pkg
//   Shared definitions for the DDFS frequency read-back path (and the keypad
//   converter that produces the tuning word).
//   - DIV_TABLE : decade-divider values selected by freq_control (7 = invalid)
//   - state_t   : read-back FSM states
//   - LATENCY   : start-to-done latency in cycles at the default widths
//   - dd_adj    : double-dabble digit correction (+3 when digit >= 5)
package ddfs_pkg;

    localparam int DEF_NUM_W  = 40;
    localparam int DEF_FREQ_W = 27;
    localparam int LATENCY    = 2 + DEF_NUM_W + DEF_FREQ_W;

    // Entry 7 is the invalid selector; it reads as zero and is flagged as err.
    localparam logic [19:0] DIV_TABLE [8] = '{
        20'd2, 20'd10, 20'd100, 20'd1000,
        20'd10000, 20'd100000, 20'd1000000, 20'd0
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter: one input bit per cycle, W cycles per
//   conversion.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     i_load     capture i_bin and start converting
//     i_bin      binary value, W bits
//     o_busy     conversion in progress
//     o_done     one-cycle pulse; o_bcd valid from this cycle until next load
//     o_bcd      packed BCD, digit 0 in [3:0]
module bin2bcd_seq
    import ddfs_pkg::*;
#(
    parameter int W      = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [W-1:0]          i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]        r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;

    // Corrected digits before the shift. The top bit of the most significant
    // digit would shift out of the register, so only its low 3 bits are kept.
    logic [4*DIGITS-2:0] w_adj;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == DIGITS - 1) begin : g_top
                assign w_adj[4*gi +: 3] = 3'(dd_adj(r_bcd[4*gi +: 4]));
            end else begin : g_mid
                assign w_adj[4*gi +: 4] = dd_adj(r_bcd[4*gi +: 4]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_bin  <= i_bin;
                r_bcd  <= '0;
                r_cnt  <= CNT_W'(W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= {w_adj, r_bin[W-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/ddfs_frequency_readback.sv
// ddfs_frequency_readback
//   Computes the frequency actually generated by the DDFS from the tuning
//   word, the decade-divider select and the mirror flags:
//     freq_hz = floor((((fw+1)*CLK_FREQ) << (mirror_x+mirror_y)) / (DIV << 10))
//   using a bit-serial restoring divider followed by a serial BCD conversion.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     start           request, sampled in IDLE only
//     fw              tuning word (7 bits)
//     freq_control    divider select 0..6, 7 is invalid
//     mirror_x/_y     mirror flags, each doubles the frequency
//     busy            high from the cycle after start is accepted until done
//     done            one-cycle pulse, results valid from this cycle
//     err             last request used freq_control == 7
//     freq_hz         result in Hz
//     freq_bcd        result in packed BCD, digit 0 in [3:0]
module ddfs_frequency_readback
    import ddfs_pkg::*;
#(
    parameter logic [63:0] CLK_FREQ = 64'd200000000,
    parameter int          NUM_W    = 40,
    parameter int          FREQ_W   = 27,
    parameter int          DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [6:0]            fw,
    input  logic [2:0]            freq_control,
    input  logic                  mirror_x,
    input  logic                  mirror_y,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [FREQ_W-1:0]     freq_hz,
    output logic [4*DIGITS-1:0]   freq_bcd
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    state_t              r_state;
    state_t              w_state_next;

    logic [6:0]          r_fw;
    logic [2:0]          r_fc;
    logic [1:0]          r_m;

    logic [NUM_W-1:0]    r_num;
    logic [NUM_W-1:0]    r_den;
    logic [NUM_W-1:0]    r_rem;
    logic [FREQ_W-1:0]   r_quo;
    logic [CNT_W-1:0]    r_cnt;

    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [FREQ_W-1:0]   r_freq_hz;
    logic [4*DIGITS-1:0] r_freq_bcd;

    logic [NUM_W:0]      w_rem_sh;
    logic [NUM_W:0]      w_sub;
    logic                w_ge;
    logic [FREQ_W-1:0]   w_quo_next;
    logic                w_bcd_load;
    logic                w_bcd_busy;
    logic                w_bcd_done;
    logic [4*DIGITS-1:0] w_bcd;

    // One restoring-division step: bring in the next numerator bit and keep
    // the difference when it does not borrow. The quotient register is only
    // FREQ_W wide, so higher quotient bits fall off the top.
    assign w_rem_sh   = {r_rem, r_num[NUM_W-1]};
    assign w_sub      = w_rem_sh - {1'b0, r_den};
    assign w_ge       = ~w_sub[NUM_W];
    assign w_quo_next = {r_quo[FREQ_W-2:0], w_ge};

    always_comb begin
        w_state_next = r_state;
        w_bcd_load   = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_DIV;
            ST_DIV: begin
                if (r_cnt == '0) begin
                    // Hand the final quotient straight to the converter on the
                    // last divide edge so no cycle is lost between phases.
                    w_bcd_load   = 1'b1;
                    w_state_next = ST_BCD;
                end
            end
            ST_BCD:  if (w_bcd_done && !w_bcd_busy) w_state_next = ST_DONE;
            // Returning through IDLE means a held start is accepted one cycle
            // after DONE.
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fw       <= '0;
            r_fc       <= '0;
            r_m        <= '0;
            r_num      <= '0;
            r_den      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_freq_hz  <= '0;
            r_freq_bcd <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fw   <= fw;
                        r_fc   <= freq_control;
                        r_m    <= {1'b0, mirror_x} + {1'b0, mirror_y};
                        r_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_num <= NUM_W'(((64'(r_fw) + 64'd1) * CLK_FREQ) << r_m);
                    r_den <= NUM_W'({DIV_TABLE[r_fc], 10'b0});
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= CNT_W'(NUM_W - 1);
                end
                ST_DIV: begin
                    r_num <= r_num << 1;
                    r_rem <= w_ge ? w_sub[NUM_W-1:0] : w_rem_sh[NUM_W-1:0];
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_BCD: begin
                    if (w_state_next == ST_DONE) begin
                        // Invalid selector divides by zero; its result is
                        // forced to zero rather than reported.
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= (r_fc == 3'd7);
                        r_freq_hz  <= (r_fc == 3'd7) ? '0 : r_quo;
                        r_freq_bcd <= (r_fc == 3'd7) ? '0 : w_bcd;
                    end
                end
                default: ;
            endcase
        end
    end

    bin2bcd_seq #(
        .W      (FREQ_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_bcd_load),
        .i_bin  (w_quo_next),
        .o_busy (w_bcd_busy),
        .o_done (w_bcd_done),
        .o_bcd  (w_bcd)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign freq_hz  = r_freq_hz;
    assign freq_bcd = r_freq_bcd;

endmodule

// File: tb/tb_ddfs_frequency_readback.sv
module tb_ddfs_frequency_readback;

    localparam longint unsigned CLK_HZ = 64'd200000000;
    localparam int LAT    = 69;
    localparam int BOUND  = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  fw;
    logic [2:0]  freq_control;
    logic        mirror_x;
    logic        mirror_y;
    logic        busy;
    logic        done;
    logic        err;
    logic [26:0] freq_hz;
    logic [31:0] freq_bcd;

    int n_checks = 0;
    int n_errors = 0;

    ddfs_frequency_readback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fw           (fw),
        .freq_control (freq_control),
        .mirror_x     (mirror_x),
        .mirror_y     (mirror_y),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .freq_hz      (freq_hz),
        .freq_bcd     (freq_bcd)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the frequency formula evaluated directly in 64-bit arithmetic.
    function automatic longint unsigned ref_hz(input int f, input int fc, input int m);
        longint unsigned divs [8] = '{2, 10, 100, 1000, 10000, 100000, 1000000, 0};
        longint unsigned num;
        if (fc == 7) return 0;
        num = (longint'(f) + 1) * CLK_HZ * (longint'(1) << m);
        return num / (divs[fc] * 1024);
    endfunction

    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One request; optionally re-pulses start and scrambles the inputs mid-divide.
    task automatic run_case(input logic [6:0] f, input logic [2:0] fc,
                            input logic mx, input logic my, input bit disturb);
        longint unsigned exp_hz;
        int cycles;
        int extra;
        exp_hz = ref_hz(int'(f), int'(fc), int'(mx) + int'(my));
        @(negedge clk);
        fw = f; freq_control = fc; mirror_x = mx; mirror_y = my; start = 1'b1;
        @(posedge clk);
        cycles = 0;
        @(negedge clk);
        start = 1'b0;
        while (cycles < BOUND) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) check_eq("busy_after_start", busy, 1);
            if (done) break;
            if (disturb && cycles == 10) begin
                start = 1'b1;
                fw = f ^ 7'h55;
                freq_control = 3'($urandom_range(0, 6));
                mirror_x = ~mx;
                mirror_y = ~my;
            end else if (disturb && cycles == 11) begin
                start = 1'b0;
            end
        end
        check_eq("latency", cycles, LAT);
        check_eq("freq_hz", freq_hz, exp_hz);
        check_eq("freq_bcd", freq_bcd, ref_bcd(exp_hz));
        check_eq("err", err, (fc == 3'd7) ? 1 : 0);
        check_eq("busy_at_done", busy, 0);
        $display("run fw=%0d fc=%0d mx=%0d my=%0d disturb=%0d hz=%0d bcd=%08h lat=%0d",
                 f, fc, mx, my, disturb, freq_hz, freq_bcd, cycles);
        extra = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_eq("no_extra_done", extra, 0);
        check_eq("hz_hold", freq_hz, exp_hz);
    endtask

    initial begin
        int cycles;
        int dones;
        rst = 1'b1; start = 1'b0; fw = '0; freq_control = '0;
        mirror_x = 1'b0; mirror_y = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_hz", freq_hz, 0);
        check_eq("rst_bcd", freq_bcd, 0);
        rst = 1'b0;
        @(negedge clk);

        run_case(7'd127, 3'd0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_hz_const", freq_hz, 12500000);
        check_eq("t1_bcd_const", freq_bcd, 32'h12500000);
        run_case(7'd0,   3'd0, 1'b0, 1'b0, 1'b0);
        check_eq("t2a_hz_const", freq_hz, 97656);
        run_case(7'd63,  3'd3, 1'b0, 1'b0, 1'b0);
        check_eq("t2b_hz_const", freq_hz, 12500);
        run_case(7'd127, 3'd6, 1'b0, 1'b0, 1'b0);
        check_eq("t2c_hz_const", freq_hz, 25);
        run_case(7'd127, 3'd0, 1'b1, 1'b1, 1'b0);
        check_eq("t3a_hz_const", freq_hz, 50000000);
        run_case(7'd127, 3'd0, 1'b0, 1'b1, 1'b0);
        check_eq("t3b_hz_const", freq_hz, 25000000);
        run_case(7'd90,  3'd7, 1'b1, 1'b0, 1'b0);
        run_case(7'd90,  3'd1, 1'b1, 1'b0, 1'b0);
        run_case(7'd45,  3'd2, 1'b0, 1'b1, 1'b1);

        // Held start: second request accepted one cycle after DONE.
        @(negedge clk);
        fw = 7'd127; freq_control = 3'd0; mirror_x = 1'b0; mirror_y = 1'b1;
        start = 1'b1;
        cycles = 0;
        while (cycles < BOUND) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done) break;
        end
        check_eq("held_first_done", done, 1);
        cycles = 0;
        while (cycles < BOUND) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        check_eq("held_interval", cycles, LAT + 2);
        check_eq("held_hz", freq_hz, 25000000);
        $display("held start interval=%0d hz=%0d", cycles, freq_hz);
        repeat (5) @(negedge clk);
        check_eq("held_idle_busy", busy, 0);

        // Reset during the BCD phase.
        run_case(7'd100, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        fw = 7'd33; freq_control = 3'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_hz", freq_hz, 0);
        check_eq("abort_bcd", freq_bcd, 0);
        check_eq("abort_err", err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        $display("reset abort dones=%0d", dones);
        run_case(7'd33, 3'd1, 1'b0, 1'b0, 1'b0);

        // Random requests against the reference formula.
        for (int i = 0; i < 20; i++) begin
            run_case(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
